// File: rtl/serie_paralelo_align.sv
// rtl/serie_paralelo_align.sv - serial-to-parallel converter with comma-based word alignment.
// Hunts for COMMA at any bit offset, locks after LOCK_COMMAS aligned commas, emits non-comma words.
module serie_paralelo_align #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
   parameter int               LOCK_COMMAS  = 4,
   parameter int               MISALIGN_MAX = 3
) (
   input  logic             clk_8f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             word_strobe,
   output logic             comma_det,
   output logic             locked
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COMMAS + 1);
   localparam int MW = $clog2(MISALIGN_MAX + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_COMMAS);
   localparam logic [MW-1:0] MIS_C    = MW'(MISALIGN_MAX);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [BW-1:0]    bit_cnt_q;
   logic [BW-1:0]    bit_cnt_d;
   logic [CW-1:0]    comma_cnt_q;
   logic [CW-1:0]    comma_inc;
   logic [MW-1:0]    mis_cnt_q;
   logic [MW-1:0]    mis_inc;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             strobe_q;
   logic             comma_det_q;
   logic             hit;
   logic             boundary;

   assign sr_d      = {sr_q[WIDTH-2:0], data_in};
   assign hit       = (sr_q == COMMA);
   assign boundary  = (bit_cnt_q == LAST_BIT);
   assign bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
   assign comma_inc = (comma_cnt_q == LOCK_C) ? comma_cnt_q : comma_cnt_q + 1'b1;
   assign mis_inc   = (mis_cnt_q == MIS_C) ? mis_cnt_q : mis_cnt_q + 1'b1;

   always_ff @(posedge clk_8f or posedge reset) begin
      if (reset) begin
         state_q     <= SEARCH;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         mis_cnt_q   <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         comma_det_q <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         comma_det_q <= 1'b0;
         case (state_q)
            SEARCH: begin
               // Restart the word counter so the next boundary lands WIDTH cycles after this comma.
               if (hit) begin
                  bit_cnt_q   <= '0;
                  comma_cnt_q <= CW'(1);
                  mis_cnt_q   <= '0;
                  state_q     <= (LOCK_COMMAS == 1) ? LOCKED : ALIGN;
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (hit) begin
                     comma_cnt_q <= comma_inc;
                     if (comma_inc == LOCK_C) begin
                        state_q   <= LOCKED;
                        mis_cnt_q <= '0;
                     end
                  end else begin
                     state_q     <= SEARCH;
                     comma_cnt_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  strobe_q <= 1'b1;
                  if (hit) begin
                     comma_det_q <= 1'b1;
                     mis_cnt_q   <= '0;
                  end else begin
                     data_q  <= sr_q;
                     valid_q <= 1'b1;
                  end
               end else if (hit) begin
                  // A comma off the word grid means the bit alignment has slipped.
                  if (mis_inc == MIS_C) begin
                     state_q     <= SEARCH;
                     comma_cnt_q <= '0;
                     mis_cnt_q   <= '0;
                  end else begin
                     mis_cnt_q <= mis_inc;
                  end
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign word_strobe = strobe_q;
   assign comma_det   = comma_det_q;
   assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_serie_paralelo_align.sv
// tb/tb_serie_paralelo_align.sv - directed bench for serie_paralelo_align (8-bit and 10-bit instances).
module tb_serie_paralelo_align;

   logic       clk;
   logic       reset;
   logic       din8;
   logic       din10;
   logic [7:0] dout8;
   logic       v8, ws8, cd8, lk8;
   logic [9:0] dout10;
   logic       v10, ws10, cd10, lk10;

   serie_paralelo_align dut8 (
      .clk_8f(clk), .reset(reset), .data_in(din8), .data_out(dout8),
      .valid_out(v8), .word_strobe(ws8), .comma_det(cd8), .locked(lk8)
   );

   serie_paralelo_align #(
      .WIDTH(10), .COMMA(10'h17C), .LOCK_COMMAS(2), .MISALIGN_MAX(3)
   ) dut10 (
      .clk_8f(clk), .reset(reset), .data_in(din10), .data_out(dout10),
      .valid_out(v10), .word_strobe(ws10), .comma_det(cd10), .locked(lk10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          exp_valid;
      int          exp_comma;
      int          exp_strobe;
      logic [15:0] exp_data;
      logic        exp_locked;
   } vec_t;

   int          n_cmp;
   int          n_fail;
   logic        sel10;
   int          n_valid, n_comma, n_strobe, n_locked;
   int          pulse_viol;
   logic [15:0] cur_data;
   logic        cur_valid, cur_comma, cur_strobe, cur_locked;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr();
      n_valid  = 0;
      n_comma  = 0;
      n_strobe = 0;
      n_locked = 0;
   endtask

   task automatic send_bit(input logic b);
      if (sel10) din10 = b;
      else       din8  = b;
      @(posedge clk);
      #1;
      cur_valid  = sel10 ? v10  : v8;
      cur_comma  = sel10 ? cd10 : cd8;
      cur_strobe = sel10 ? ws10 : ws8;
      cur_locked = sel10 ? lk10 : lk8;
      cur_data   = sel10 ? {6'd0, dout10} : {8'd0, dout8};
      if (cur_valid)  n_valid++;
      if (cur_comma)  n_comma++;
      if (cur_strobe) n_strobe++;
      if (cur_locked) n_locked++;
      if ((cur_valid || cur_comma || cur_strobe) && !cur_locked) pulse_viol++;
   endtask

   task automatic send_word(input logic [15:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      din8  = 1'b0;
      din10 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   vec_t        vecs[9];
   logic [7:0]  win;
   logic        b;
   int          idle_bad;

   initial begin
      n_cmp = 0; n_fail = 0; pulse_viol = 0; idle_bad = 0;
      sel10 = 1'b0;
      reset = 1'b1; din8 = 1'b0; din10 = 1'b0;
      clr();

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_data_out", {24'd0, dout8}, 32'h0);
      check("rst_valid", {31'd0, v8}, 32'h0);
      check("rst_strobe", {31'd0, ws8}, 32'h0);
      check("rst_comma_det", {31'd0, cd8}, 32'h0);
      check("rst_locked", {31'd0, lk8}, 32'h0);
      check("rst_locked10", {31'd0, lk10}, 32'h0);
      reset = 1'b0;

      // Idle: random bits that never form a 0xBC window
      win = 8'h00;
      for (int i = 0; i < 200; i++) begin
         b = 1'($urandom_range(0, 1));
         if ({win[6:0], b} == 8'hBC) b = ~b;
         win = {win[6:0], b};
         send_bit(b);
         if (cur_locked || cur_valid || cur_data != 16'h0) idle_bad++;
      end
      check("idle_quiet", idle_bad, 0);

      // Lock at bit offset 3, then A5 / BC / 3C with comma suppression
      vecs[0] = '{16'h00BC, 0, 0, 0, 16'h0000, 1'b0};
      vecs[1] = '{16'h00BC, 0, 0, 0, 16'h0000, 1'b0};
      vecs[2] = '{16'h00BC, 0, 0, 0, 16'h0000, 1'b0};
      vecs[3] = '{16'h00BC, 0, 0, 0, 16'h0000, 1'b0};
      vecs[4] = '{16'h00A5, 0, 0, 0, 16'h0000, 1'b1};
      vecs[5] = '{16'h00BC, 1, 0, 1, 16'h00A5, 1'b1};
      vecs[6] = '{16'h003C, 0, 1, 1, 16'h00A5, 1'b1};
      vecs[7] = '{16'h00BC, 1, 0, 1, 16'h003C, 1'b1};
      vecs[8] = '{16'h0000, 0, 1, 1, 16'h003C, 1'b1};
      do_reset();
      send_word(16'h0, 3);
      for (int i = 0; i < 9; i++) begin
         clr();
         send_word(vecs[i].word, 8);
         check($sformatf("vec%0d_valid", i), n_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_comma", i), n_comma, vecs[i].exp_comma);
         check($sformatf("vec%0d_strobe", i), n_strobe, vecs[i].exp_strobe);
         check($sformatf("vec%0d_data", i), {16'd0, cur_data}, {16'd0, vecs[i].exp_data});
         check($sformatf("vec%0d_locked", i), {31'd0, cur_locked}, {31'd0, vecs[i].exp_locked});
      end

      // Broken alignment: BC, BC, 00 must restart the hunt from zero
      do_reset();
      clr();
      send_word(16'hBC, 8); send_word(16'hBC, 8); send_word(16'h00, 8);
      send_word(16'hBC, 8); send_word(16'hBC, 8); send_word(16'hBC, 8);
      send_bit(1'b1);
      check("broken_no_lock", n_locked, 0);
      send_word(16'h3C, 7);
      send_bit(1'b0);
      check("broken_relock", {31'd0, cur_locked}, 32'h1);

      // Unlock: one slipped bit, three misaligned commas, then relock
      do_reset();
      for (int i = 0; i < 4; i++) send_word(16'hBC, 8);
      send_word(16'h11, 8);
      clr();
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_word(16'hBC, 8);
      check("slip_valid_cnt", n_valid, 4);
      check("slip_comma_cnt", n_comma, 0);
      check("slip_data", {16'd0, cur_data}, 32'h5E);
      check("slip_still_locked", {31'd0, cur_locked}, 32'h1);
      send_bit(1'b1);
      check("slip_unlocked", {31'd0, cur_locked}, 32'h0);
      send_word(16'h3C, 7);
      for (int i = 0; i < 3; i++) send_word(16'hBC, 8);
      check("relock_not_yet", {31'd0, cur_locked}, 32'h0);
      send_word(16'h66, 8);
      check("relock_locked", {31'd0, cur_locked}, 32'h1);
      clr();
      send_word(16'h00, 8);
      check("relock_valid", n_valid, 1);
      check("relock_data", {16'd0, cur_data}, 32'h66);

      // 10-bit instance, LOCK_COMMAS=2, then asynchronous reset mid-word
      sel10 = 1'b1;
      do_reset();
      send_word(16'h17C, 10);
      send_word(16'h17C, 10);
      check("w10_lock_pending", {31'd0, cur_locked}, 32'h0);
      send_word(16'h2AA, 10);
      check("w10_locked", {31'd0, cur_locked}, 32'h1);
      clr();
      send_word(16'h17C >> 7, 3);
      check("w10_valid", n_valid, 1);
      check("w10_data", {16'd0, cur_data}, 32'h2AA);
      #1;
      reset = 1'b1;
      #1;
      check("w10_async_data", {22'd0, dout10}, 32'h0);
      check("w10_async_locked", {31'd0, lk10}, 32'h0);
      check("w10_async_valid", {31'd0, v10}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      check("pulses_only_locked", pulse_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
